turn_scheduler: RTL and testbench

- Multi-player turn controller for the board game.
- Time-shares the single dice → position_tracker → snakes_ladders → game_end datapath among up to 4 players.
- Owns each player's position register and sequences each turn: capture the dice value, present the current player's position to the shared movement datapath, write back the adjusted position, detect a win, and pass the turn.
- Sits between the roll button and the existing movement datapath.

---
 rtl/turn_scheduler.sv | 119 +++++++++++
 tb/tb_turn_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_scheduler.sv
// ============================================================================
// Module   : turn_scheduler
// Purpose  : Shares one dice/movement datapath among 2..4 players, owns the
//            position registers and sequences IDLE -> MOVE -> DONE per turn.
// Options  : EXTRA_TURN_ON_SIX_EN - a valid six grants the same player a bonus roll.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module turn_scheduler #(
  parameter int NUM_PLAYERS = 4,
  parameter int WIN_POS     = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_req,
  input  logic [2:0] dice_value,
  output logic [6:0] mv_pos,
  output logic [2:0] mv_dice,
  input  logic [6:0] adj_pos,
  output logic [1:0] cur_player,
  output logic       busy,
  output logic       turn_done,
  output logic       win,
  output logic [1:0] winner,
  input  logic [1:0] rd_sel,
  output logic [6:0] rd_pos
);

  localparam logic [6:0] c_WIN_POS = 7'(WIN_POS);
  localparam logic [1:0] c_LAST    = 2'(NUM_PLAYERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DONE = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t     r_state;
  logic [6:0] r_pos [0:3];
  logic [1:0] r_cur;
  logic [1:0] r_winner;
  logic [2:0] r_dice;
  logic       r_busy;
  logic       r_done;
  logic       r_win;

  logic       w_dice_ok;
  logic       w_bonus;
  logic [1:0] w_next;

  assign w_dice_ok = (r_dice != 3'd0) && (r_dice != 3'd7);

`ifdef EXTRA_TURN_ON_SIX_EN
  // A six is always a valid value, so no separate validity term is needed.
  assign w_bonus = (r_dice == 3'd6);
`else
  assign w_bonus = 1'b0;
`endif

  assign w_next = w_bonus ? r_cur : ((r_cur == c_LAST) ? 2'd0 : r_cur + 2'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_pos[i] <= '0;
      r_state  <= S_IDLE;
      r_cur    <= '0;
      r_dice   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_win    <= 1'b0;
      r_winner <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (roll_req) begin
            r_dice  <= dice_value;
            r_busy  <= 1'b1;
            r_state <= S_MOVE;
          end
        end
        S_MOVE: begin
          // Invalid dice and overshoot both consume the turn without moving.
          if (w_dice_ok && (adj_pos <= c_WIN_POS)) r_pos[r_cur] <= adj_pos;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (r_pos[r_cur] == c_WIN_POS) begin
            r_win    <= 1'b1;
            r_winner <= r_cur;
            r_state  <= S_OVER;
          end else begin
            r_cur   <= w_next;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_OVER;
        end
      endcase
    end
  end

  assign mv_pos     = r_pos[r_cur];
  assign mv_dice    = r_dice;
  assign cur_player = r_cur;
  assign busy       = r_busy;
  assign turn_done  = r_done;
  assign win        = r_win;
  assign winner     = r_winner;
  assign rd_pos     = (int'(rd_sel) < NUM_PLAYERS) ? r_pos[rd_sel] : 7'd0;

endmodule

`default_nettype wire

// File: tb/tb_turn_scheduler.sv
// ============================================================================
// Module   : tb_turn_scheduler
// Purpose  : Directed bench for turn_scheduler with a snakes_ladders model
//            and a per-turn expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_turn_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       roll_req;
  logic [2:0] dice_value;
  logic [6:0] mv_pos;
  logic [2:0] mv_dice;
  logic [6:0] adj_pos;
  logic [1:0] cur_player;
  logic       busy;
  logic       turn_done;
  logic       win;
  logic [1:0] winner;
  logic [1:0] rd_sel;
  logic [6:0] rd_pos;

  logic       force_en;
  logic [6:0] force_val;

  int checks   = 0;
  int failures = 0;
  int pos_m [4];
  int cur_m;

  typedef struct {
    int player;
    int pos;
    int next_cur;
    bit win;
  } exp_t;
  exp_t sb [$];

  turn_scheduler #(.NUM_PLAYERS(4), .WIN_POS(100)) dut (
    .clk        (clk),
    .reset      (reset),
    .roll_req   (roll_req),
    .dice_value (dice_value),
    .mv_pos     (mv_pos),
    .mv_dice    (mv_dice),
    .adj_pos    (adj_pos),
    .cur_player (cur_player),
    .busy       (busy),
    .turn_done  (turn_done),
    .win        (win),
    .winner     (winner),
    .rd_sel     (rd_sel),
    .rd_pos     (rd_pos)
  );

  always #5 clk = ~clk;

  // snakes_ladders model: plain sum, one ladder 9 -> 31, optional override
  logic [6:0] w_sum;
  always_comb begin
    w_sum   = mv_pos + {4'd0, mv_dice};
    adj_pos = force_en ? force_val : ((w_sum == 7'd9) ? 7'd31 : w_sum);
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) pos_m[i] = 0;
    cur_m = 0;
  endtask

  task automatic check_positions(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      check(tag, 32'(rd_pos), 32'(pos_m[i]));
    end
  endtask

  task automatic play(input int dice, input bit fen, input int fval, input bit hold);
    exp_t e;
    int   adj;
    int   k;
    bit   seen;
    e.player = cur_m;
    e.pos    = pos_m[cur_m];
    if (dice >= 1 && dice <= 6) begin
      adj = fen ? fval : pos_m[cur_m] + dice;
      if (!fen && adj == 9) adj = 31;
      if (adj <= 100) e.pos = adj;
    end
    e.win = (e.pos == 100);
    if (e.win) e.next_cur = cur_m;
    else begin
      e.next_cur = (cur_m == 3) ? 0 : cur_m + 1;
`ifdef EXTRA_TURN_ON_SIX_EN
      if (dice == 6) e.next_cur = cur_m;
`endif
    end
    sb.push_back(e);

    force_en   = fen;
    force_val  = 7'(fval);
    dice_value = 3'(dice);
    roll_req   = 1'b1;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 6) begin
      tick();
      k++;
      if (k == 1) begin
        check("mv_pos_in_move", 32'(mv_pos), 32'(pos_m[cur_m]));
        check("mv_dice_in_move", 32'(mv_dice), 32'(dice & 7));
        check("busy_in_move", 32'(busy), 32'd1);
      end
      if (!hold) roll_req = 1'b0;
      if (turn_done) seen = 1'b1;
    end
    check("turn_done_seen", 32'(seen), 32'd1);
    check("turn_latency", 32'(k), 32'd2);
    e = sb.pop_front();
    rd_sel = 2'(e.player);
    #1;
    check("pos_writeback", 32'(rd_pos), 32'(e.pos));
    tick();
    roll_req = 1'b0;
    #1;
    check("turn_done_one_cycle", 32'(turn_done), 32'd0);
    check("cur_player_after", 32'(cur_player), 32'(e.next_cur));
    check("win_after", 32'(win), 32'(e.win));
    pos_m[e.player] = e.pos;
    cur_m = e.next_cur;
  endtask

  initial begin
    int pulses;
    reset      = 1'b0;
    roll_req   = 1'b0;
    dice_value = 3'd0;
    rd_sel     = 2'd0;
    force_en   = 1'b0;
    force_val  = 7'd0;

    do_reset();
    check_positions("reset_pos");
    check("reset_cur", 32'(cur_player), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_turn_done", 32'(turn_done), 32'd0);
    check("reset_win", 32'(win), 32'd0);
    check("reset_winner", 32'(winner), 32'd0);
    check("reset_mv_dice", 32'(mv_dice), 32'd0);

    play(4, 1'b0, 0, 1'b0);      // p0: 0 -> 4
    play(5, 1'b0, 0, 1'b0);      // p1: 0 -> 5
    play(7, 1'b0, 0, 1'b0);      // p2: invalid dice, stays 0
    play(3, 1'b1, 104, 1'b0);    // p3: overshoot guard, stays 0
    play(1, 1'b0, 0, 1'b0);      // p0: 4 -> 5

    play(4, 1'b0, 0, 1'b1);      // p1: 5 -> 9 -> ladder 31, roll_req held
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (turn_done) pulses++;
    end
    check("held_roll_extra_pulses", 32'(pulses), 32'd0);
    check("held_roll_busy", 32'(busy), 32'd0);
    check_positions("after_ladder_pos");

    play(6, 1'b0, 0, 1'b0);      // p2: six
`ifdef EXTRA_TURN_ON_SIX_EN
    play(1, 1'b0, 0, 1'b0);      // bonus roll for p2
`endif
    play(2, 1'b1, 97, 1'b0);     // p3 -> 97, wraps to p0
    check("wrap_to_p0", 32'(cur_player), 32'd0);
    play(1, 1'b0, 0, 1'b0);
    play(1, 1'b0, 0, 1'b0);
    play(1, 1'b0, 0, 1'b0);
    play(3, 1'b0, 0, 1'b0);      // p3: 97 -> 100 wins
    check("win_flag", 32'(win), 32'd1);
    check("winner_idx", 32'(winner), 32'd3);
    check("win_cur_holds", 32'(cur_player), 32'd3);
    check("win_busy", 32'(busy), 32'd0);

    roll_req   = 1'b1;
    dice_value = 3'd2;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (turn_done || busy) pulses++;
    end
    roll_req = 1'b0;
    check("game_over_no_turn", 32'(pulses), 32'd0);
    check("game_over_win_holds", 32'(win), 32'd1);
    check_positions("game_over_frozen");

    do_reset();
    check("reset_clears_win", 32'(win), 32'd0);
    play(2, 1'b0, 0, 1'b0);      // p0: 0 -> 2
    dice_value = 3'd4;
    roll_req   = 1'b1;
    tick();
    roll_req = 1'b0;
    check("abort_in_move_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) pos_m[i] = 0;
    cur_m = 0;
    check("abort_turn_done", 32'(turn_done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cur", 32'(cur_player), 32'd0);
    check_positions("abort_pos");
    tick();
    check("abort_no_late_pulse", 32'(turn_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
